// File: rtl/reg_access_ctrl_pkg.sv
// Shared definitions for the register access sequencer: FSM states, default
// geometry, parked bus address and register offsets.
package reg_access_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  localparam int unsigned ADDR_W_DEF   = 4;
  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned NUM_REGS_DEF = 4;
  localparam int unsigned RD_LAT_DEF   = 1;
  localparam int unsigned LAT_W        = 3;

  localparam logic [ADDR_W_DEF-1:0] IDLE_ADDR_DEF = 4'hF;

  localparam logic [ADDR_W_DEF-1:0] REG0 = 4'd0;
  localparam logic [ADDR_W_DEF-1:0] REG1 = 4'd1;
  localparam logic [ADDR_W_DEF-1:0] REG2 = 4'd2;
  localparam logic [ADDR_W_DEF-1:0] REG3 = 4'd3;

endpackage

// File: rtl/reg_access_ctrl_if.sv
// Command/response handshake bundle between a bus master and the register sequencer.
interface reg_access_ctrl_if
  import reg_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/reg_access_ctrl.sv
// Register master: one command per handshake, fixed setup/strobe timing toward the
// register block, programmable read capture latency, one response per command.
module reg_access_ctrl
  import reg_access_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter int unsigned       NUM_REGS  = NUM_REGS_DEF,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = ADDR_W'(IDLE_ADDR_DEF),
  parameter int unsigned       RD_LAT    = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              resetb,
  reg_access_ctrl_if.slave  bus,
  output logic [ADDR_W-1:0] address,
  output logic              write_en,
  output logic              read_en,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] read_data
);

  state_t            state;
  logic              lat_write;
  logic [DATA_W-1:0] lat_wdata;
  logic [LAT_W-1:0]  lat_cnt;
  logic              cmd_legal_c;

  assign cmd_legal_c = (32'(bus.cmd_addr) < NUM_REGS);

  // Address is held from accept until the response; strobes default low every cycle.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state         <= ST_IDLE;
      address       <= IDLE_ADDR;
      write_en      <= 1'b0;
      read_en       <= 1'b0;
      data_in       <= '0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      lat_write     <= 1'b0;
      lat_wdata     <= '0;
      lat_cnt       <= '0;
    end else begin
      write_en <= 1'b0;
      read_en  <= 1'b0;
      data_in  <= '0;
      case (state)
        ST_IDLE: begin
          bus.cmd_ready <= 1'b1;
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_ready <= 1'b0;
            lat_write     <= bus.cmd_write;
            lat_wdata     <= bus.cmd_wdata;
            if (cmd_legal_c) begin
              state   <= ST_SETUP;
              address <= bus.cmd_addr;
            end else begin
              // Illegal address: answer at once, the register bus never moves.
              state         <= ST_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
            end
          end
        end
        ST_SETUP: begin
          state    <= ST_STROBE;
          write_en <= lat_write;
          read_en  <= !lat_write;
          data_in  <= lat_write ? lat_wdata : '0;
        end
        ST_STROBE: begin
          if (lat_write) begin
            state         <= ST_RESP;
            address       <= IDLE_ADDR;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
          end else begin
            state   <= ST_WAIT;
            lat_cnt <= LAT_W'(RD_LAT - 1);
          end
        end
        ST_WAIT: begin
          if (lat_cnt == '0) begin
            state         <= ST_RESP;
            address       <= IDLE_ADDR;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= read_data;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state         <= ST_IDLE;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.cmd_ready <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          address <= IDLE_ADDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl: directed register traffic, response back-pressure, reset
// abort and randomized commands, all checked each cycle against a transaction model.
`timescale 1ns/1ps
module tb_reg_access_ctrl;
  import reg_access_ctrl_pkg::*;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned NREGS = 4;
  localparam int unsigned RDL   = 1;
  localparam logic [AW-1:0] PARK = 4'hF;

  logic clk_tb = 1'b0;
  logic resetb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  reg_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic [AW-1:0] address;
  logic          write_en;
  logic          read_en;
  logic [DW-1:0] data_in;
  logic [DW-1:0] read_data = '0;

  reg_access_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NREGS), .IDLE_ADDR(PARK), .RD_LAT(RDL)
  ) dut (
    .clk(clk_tb), .resetb(resetb), .bus(bus),
    .address(address), .write_en(write_en), .read_en(read_en),
    .data_in(data_in), .read_data(read_data)
  );

  // Device register block: samples strobes on the edge, read data one edge later.
  logic [DW-1:0] dev_mem [NREGS] = '{default: 8'h00};
  always @(posedge clk_tb) begin
    if (write_en && 32'(address) < NREGS) dev_mem[address[1:0]] <= data_in;
    if (read_en) read_data <= (32'(address) < NREGS) ? dev_mem[address[1:0]] : 8'hEE;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk_tb) cyc++;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Transaction-level model state
  logic [DW-1:0] ref_mem [NREGS] = '{default: 8'h00};
  bit            armed = 1'b0;
  bit            busy  = 1'b0;
  int            acc_n, rsp_at;
  bit            m_write, m_legal, seen_rsp;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  // Observations of the DUT used by the literal checks
  int            dut_we = 0, dut_re = 0, dut_acc = 0, hold_cnt = 0, last_lat = -1;
  logic [AW-1:0] last_we_addr = '0;
  logic [DW-1:0] last_we_data = '0, last_rdata = '0;
  logic          last_err = 1'b0;

  always @(negedge clk_tb) begin
    bit            e_ready, e_rv, e_we, e_re;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    if (write_en) begin dut_we++; last_we_addr = address; last_we_data = data_in; end
    if (read_en) dut_re++;
    if (bus.cmd_valid && bus.cmd_ready) dut_acc++;
    if (bus.rsp_valid && !bus.rsp_ready) hold_cnt++;
    if (!resetb) begin
      busy  = 1'b0;
      armed = 1'b0;
      check("rst_cmd_ready", 32'(bus.cmd_ready), 0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
      check("rst_rsp_err",   32'(bus.rsp_err), 0);
      check("rst_address",   32'(address), 32'(PARK));
      check("rst_strobes",   32'({write_en, read_en}), 0);
      check("rst_data_in",   32'(data_in), 0);
    end else begin
      e_ready = armed && !busy;
      e_rv    = busy && cyc >= rsp_at;
      e_we    = busy && m_legal && m_write && cyc == acc_n + 1;
      e_re    = busy && m_legal && !m_write && cyc == acc_n + 1;
      e_addr  = (busy && m_legal && cyc < rsp_at) ? m_addr : PARK;
      e_din   = e_we ? m_wdata : '0;
      check("cmd_ready", 32'(bus.cmd_ready), 32'(e_ready));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
      check("write_en",  32'(write_en), 32'(e_we));
      check("read_en",   32'(read_en), 32'(e_re));
      check("address",   32'(address), 32'(e_addr));
      check("data_in",   32'(data_in), 32'(e_din));
      if (e_rv) begin
        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(m_rdata));
        check("rsp_err",   32'(bus.rsp_err), 32'(!m_legal));
        if (!seen_rsp && bus.rsp_valid) begin seen_rsp = 1'b1; last_lat = cyc + 1 - acc_n; end
      end
      // Advance the model across the coming edge
      if (e_we) ref_mem[m_addr[1:0]] = m_wdata;
      if (e_rv && bus.rsp_ready) begin
        busy       = 1'b0;
        last_rdata = bus.rsp_rdata;
        last_err   = bus.rsp_err;
      end else if (e_ready && bus.cmd_valid) begin
        busy     = 1'b1;
        acc_n    = cyc + 1;
        m_write  = bus.cmd_write;
        m_addr   = bus.cmd_addr;
        m_wdata  = bus.cmd_wdata;
        m_legal  = 32'(bus.cmd_addr) < NREGS;
        rsp_at   = !m_legal ? acc_n : (m_write ? acc_n + 2 : acc_n + 2 + int'(RDL));
        m_rdata  = (m_legal && !m_write) ? ref_mem[bus.cmd_addr[1:0]] : '0;
        seen_rsp = 1'b0;
        last_lat = -1;
      end
      armed = 1'b1;
    end
  end

  bit   rr_rand  = 1'b0;
  logic rr_force = 1'b1;
  initial bus.rsp_ready = 1'b1;
  always @(posedge clk_tb) begin
    #1;
    bus.rsp_ready = rr_rand ? ($urandom_range(0, 3) != 0) : rr_force;
  end

  task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int t = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    forever begin
      @(negedge clk_tb);
      if (bus.cmd_ready) break;
      if (++t > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: got no cmd_ready, expected accept within 200 cycles");
        break;
      end
    end
    @(posedge clk_tb); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = AW'($urandom);
    bus.cmd_wdata = DW'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (busy) begin
      @(posedge clk_tb); #1;
      if (++t > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL drain_timeout: got busy, expected response within 200 cycles");
        break;
      end
    end
  endtask

  initial begin
    int we0, re0, acc0;
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0, re0, acc0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    repeat (3) @(posedge clk_tb);
    #1 resetb = 1'b1;
    @(negedge clk_tb); #1;
    check("ready_before_first_edge", 32'(bus.cmd_ready), 0);
    @(posedge clk_tb); #1;
    check("ready_after_first_edge", 32'(bus.cmd_ready), 1);

    we0 = dut_we; re0 = dut_re;
    send(1'b1, REG0, 8'hA5); drain();
    check("wr0_pulses",  32'(dut_we - we0), 1);
    check("wr0_no_read", 32'(dut_re - re0), 0);
    check("wr0_addr",    32'(last_we_addr), 0);
    check("wr0_data",    32'(last_we_data), 32'h A5);
    check("wr0_err",     32'(last_err), 0);
    check("wr0_latency", 32'(last_lat), 3);

    re0 = dut_re;
    send(1'b0, REG0, 8'h00); drain();
    check("rd0_data",    32'(last_rdata), 32'hA5);
    check("rd0_latency", 32'(last_lat), 4);
    check("rd0_pulses",  32'(dut_re - re0), 1);

    send(1'b1, REG1, 8'hA6); drain();
    send(1'b1, REG2, 8'hA7); drain();
    send(1'b1, REG3, 8'hA8); drain();
    for (int i = 1; i <= 3; i++) begin
      send(1'b0, AW'(i), 8'h00); drain();
      check("rdback_data", 32'(last_rdata), 32'(8'hA5 + i));
    end

    we0 = dut_we; re0 = dut_re;
    send(1'b0, 4'h9, 8'h00); drain();
    check("bad_err",     32'(last_err), 1);
    check("bad_rdata",   32'(last_rdata), 0);
    check("bad_strobes", 32'((dut_re - re0) + (dut_we - we0)), 0);
    check("bad_latency", 32'(last_lat), 1);

    // Back-pressure: response held while the next command waits upstream
    rr_force = 1'b0;
    send(1'b0, REG3, 8'h00);
    acc0 = dut_acc; hold_cnt = 0;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = REG0; bus.cmd_wdata = 8'h11;
    repeat (10) @(posedge clk_tb);
    #1;
    check("hold_no_accept", 32'(dut_acc - acc0), 0);
    check("hold_cycles_ge5", 32'(hold_cnt >= 5), 1);
    rr_force = 1'b1;
    send(1'b1, REG0, 8'h11); drain();
    send(1'b0, REG0, 8'h00); drain();
    check("after_hold_rd", 32'(last_rdata), 32'h11);

    // Reset during the write strobe aborts the access
    send(1'b1, REG2, 8'h5C);
    @(posedge clk_tb); #2;
    check("strobe_before_rst", 32'(write_en), 1);
    resetb = 1'b0;
    #1;
    check("strobe_after_rst", 32'(write_en), 0);
    check("rsp_after_rst",    32'(bus.rsp_valid), 0);
    repeat (2) @(posedge clk_tb);
    #1 resetb = 1'b1;
    send(1'b0, REG2, 8'h00); drain();
    check("abort_kept_reg2", 32'(last_rdata), 32'hA7);

    // Randomized traffic with random response back-pressure
    rr_rand = 1'b1;
    for (int k = 0; k < 80; k++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(4, 15)) : AW'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(posedge clk_tb);
      #1;
      send(1'($urandom), a, DW'($urandom));
    end
    drain();
    rr_rand = 1'b0;
    repeat (3) @(posedge clk_tb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
